img_uart_loader: RTL

Byte-stream-to-frame-RAM loader for the VGA image receiver. Sits between the UART receiver and the write port of the 2^14 x 8 image RAM read by the VGA pixel pipeline. Each received byte is one 8-bit RGB pixel, written sequentially from address 0 for a 100x100 image (10000 bytes). Stalled or corrupted transfers are aborted so the next transmission starts cleanly at address 0.

---
 rtl/img_uart_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/img_uart_loader.sv
// Loads a UART byte stream into the image RAM, one pixel per byte from address 0; aborts on rx_error (or idle timeout when IMG_LOADER_TIMEOUT_EN is defined).
// Latency: rx_valid at T -> RAM write at T+1; write_done at T+2 after the last byte; load_error one cycle after the abort cause.
// Backpressure: none, one byte per cycle accepted; the upstream UART cannot be stalled.
module img_uart_loader #(
    parameter int PIXELS         = 10000,
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              write_done,
    output logic              load_error
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              timeout;

`ifdef IMG_LOADER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap;

    // Abort on the cycle the gap would reach TIMEOUT_CYCLES so load_error lands at T+TIMEOUT_CYCLES+1.
    assign timeout = (gap == GAP_LAST) && !rx_valid;

    always_ff @(posedge clk_in) begin
        if (reset || state != LOAD || rx_valid) begin
            gap <= '0;
        end else if (!timeout) begin
            gap <= gap + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            write_done <= 1'b0;
            load_error <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            write_done <= 1'b0;
            load_error <= 1'b0;
            case (state)
                LOAD: begin
                    if (rx_error || timeout) begin
                        load_error <= 1'b1;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else if (rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt;
                        wr_data <= rx_data;
                        if (cnt == LAST_ADDR) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE behaves like IDLE so a byte arriving here starts the next frame.
                    write_done <= (state == DONE);
                    busy       <= 1'b0;
                    cnt        <= '0;
                    state      <= IDLE;
                    if (rx_valid && !rx_error) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= rx_data;
                        if (LAST_ADDR == '0) begin
                            state <= DONE;
                        end else begin
                            cnt   <= ADDR_W'(1);
                            busy  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
            endcase
        end
    end

endmodule
